// File: rtl/inventory_fsm.sv
// Inventory tracker: per-item ABSENT/HELD/BROKEN state with wear counters under a carry limit.
// Drops, then one use, then ascending-index picks are resolved each cycle; all outputs are registered.
module inventory_fsm #(
    parameter int NUM_ITEMS = 4,
    parameter int CAPACITY  = 2,
    parameter int MAX_USES  = 3,
    parameter int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ITEMS-1:0] pick,
    input  logic [NUM_ITEMS-1:0] drop,
    input  logic                 use_valid,
    input  logic [IDX_W-1:0]     use_idx,
    output logic [NUM_ITEMS-1:0] has,
    output logic [NUM_ITEMS-1:0] broken,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 use_ok,
    output logic                 reject
);

    localparam int WEAR_W = $clog2(MAX_USES + 1);

    typedef enum logic [1:0] {
        ABSENT = 2'd0,
        HELD   = 2'd1,
        BROKEN = 2'd2
    } item_state_e;

    item_state_e          state_q [NUM_ITEMS];
    item_state_e          state_d [NUM_ITEMS];
    logic [WEAR_W-1:0]    wear_q  [NUM_ITEMS];
    logic [WEAR_W-1:0]    wear_d  [NUM_ITEMS];

    logic [NUM_ITEMS-1:0] has_q, has_d;
    logic [NUM_ITEMS-1:0] broken_q, broken_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 use_ok_q, use_ok_d;
    logic                 reject_q, reject_d;

    int                   n_drop;
    int                   n_brk;
    int                   n_grant;
    int                   avail;
    logic                 use_acc;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            state_d[i] = state_q[i];
            wear_d[i]  = wear_q[i];
        end
        n_drop   = 0;
        n_brk    = 0;
        n_grant  = 0;
        avail    = 0;
        use_acc  = 1'b0;
        reject_d = 1'b0;

        // Drops only affect held items; anything else is silently ignored.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (drop[i] && state_q[i] == HELD) begin
                state_d[i] = ABSENT;
                n_drop     = n_drop + 1;
            end
        end

        // A use racing a drop of the same item loses; out-of-range indices match no item.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (use_valid && int'(use_idx) == i && state_q[i] == HELD && !drop[i]) begin
                use_acc   = 1'b1;
                wear_d[i] = wear_q[i] + WEAR_W'(1);
                if (wear_d[i] == WEAR_W'(MAX_USES)) begin
                    state_d[i] = BROKEN;
                    n_brk      = n_brk + 1;
                end
            end
        end
        if (use_valid && !use_acc) begin
            reject_d = 1'b1;
        end
        use_ok_d = use_acc;

        // Slots freed by this cycle's drops and break are usable by this cycle's picks.
        avail = CAPACITY - int'(count_q) + n_drop + n_brk;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (pick[i]) begin
                if (state_q[i] == ABSENT) begin
                    if (n_grant < avail) begin
                        state_d[i] = HELD;
                        n_grant    = n_grant + 1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (state_q[i] == BROKEN) begin
                    reject_d = 1'b1;
                end
            end
        end

        count_d = CNT_W'(int'(count_q) - n_drop - n_brk + n_grant);
        full_d  = (count_d == CNT_W'(CAPACITY));
        for (int i = 0; i < NUM_ITEMS; i++) begin
            has_d[i]    = (state_d[i] == HELD);
            broken_d[i] = (state_d[i] == BROKEN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                state_q[i] <= ABSENT;
                wear_q[i]  <= '0;
            end
            has_q    <= '0;
            broken_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            use_ok_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                state_q[i] <= state_d[i];
                wear_q[i]  <= wear_d[i];
            end
            has_q    <= has_d;
            broken_q <= broken_d;
            count_q  <= count_d;
            full_q   <= full_d;
            use_ok_q <= use_ok_d;
            reject_q <= reject_d;
        end
    end

    assign has    = has_q;
    assign broken = broken_q;
    assign count  = count_q;
    assign full   = full_q;
    assign use_ok = use_ok_q;
    assign reject = reject_q;

endmodule
